mem_access_sequencer: RTL and testbench

- Sequences the shared 1K x 16 block memory (1-cycle synchronous read) between two requesters: instruction fetch, which loads the IR, and data load/store from the stack datapath.
- Accepts single-cycle request pulses, latches each command, and arbitrates between them with a starvation guard.
- Drives the memory port registered, and generates the IR write strobe and the completion pulses.
- Sits between the PC/stack control logic and the memory/IR/extender subsystem.

---
 rtl/mem_access_sequencer.sv | 141 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Sequences the shared 1-cycle-read block memory between instruction fetch and
// stack data accesses, with a bounded data streak while a fetch is waiting.
module mem_access_sequencer #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 16,
  parameter int DATA_STREAK_MAX = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addra,
  output logic              mem_wea,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              ir_write,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ISSUE_F, WAIT_F, ISSUE_D, WAIT_D} state_t;

  localparam logic [2:0] STREAK_MAX = 3'(DATA_STREAK_MAX);

  state_t              r_state;
  state_t              w_next;
  logic                r_f_pend;
  logic                r_d_pend;
  logic [ADDR_W-1:0]   r_f_addr;
  logic [ADDR_W-1:0]   r_d_addr;
  logic                r_d_we;
  logic [DATA_W-1:0]   r_d_wdata;
  logic                r_cur_we;
  logic [2:0]          r_streak;

  logic                w_arb;
  logic                w_f_cand;
  logic                w_d_cand;
  logic                w_grant_f;
  logic                w_grant_d;
  logic [ADDR_W-1:0]   w_f_addr;
  logic [ADDR_W-1:0]   w_d_addr;
  logic                w_d_we;
  logic [DATA_W-1:0]   w_d_wdata;

  // Candidates include a request arriving on the arbitration edge itself.
  always_comb begin
    w_arb     = (r_state == IDLE) || (r_state == WAIT_F) || (r_state == WAIT_D);
    w_f_cand  = r_f_pend | fetch_req;
    w_d_cand  = r_d_pend | data_req;
    w_grant_d = w_arb && w_d_cand && (!w_f_cand || (r_streak != STREAK_MAX));
    w_grant_f = w_arb && w_f_cand && !w_grant_d;
    w_f_addr  = r_f_pend ? r_f_addr  : fetch_addr;
    w_d_addr  = r_d_pend ? r_d_addr  : data_addr;
    w_d_we    = r_d_pend ? r_d_we    : data_we;
    w_d_wdata = r_d_pend ? r_d_wdata : data_wdata;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ISSUE_F: w_next = WAIT_F;
      ISSUE_D: w_next = WAIT_D;
      default: begin
        if (w_grant_d)      w_next = ISSUE_D;
        else if (w_grant_f) w_next = ISSUE_F;
        else                w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    ir_write = (r_state == WAIT_F);
    busy     = (r_state != IDLE) || r_f_pend || r_d_pend;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_f_pend   <= 1'b0;
      r_d_pend   <= 1'b0;
      r_f_addr   <= '0;
      r_d_addr   <= '0;
      r_d_we     <= 1'b0;
      r_d_wdata  <= '0;
      r_cur_we   <= 1'b0;
      r_streak   <= '0;
      mem_addra  <= '0;
      mem_wea    <= 1'b0;
      mem_dina   <= '0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      data_rdata <= '0;
    end else begin
      // A pulse while already pending is dropped; the first command wins.
      if (w_grant_f) begin
        r_f_pend <= 1'b0;
      end else if (fetch_req && !r_f_pend) begin
        r_f_pend <= 1'b1;
        r_f_addr <= fetch_addr;
      end

      if (w_grant_d) begin
        r_d_pend <= 1'b0;
      end else if (data_req && !r_d_pend) begin
        r_d_pend  <= 1'b1;
        r_d_addr  <= data_addr;
        r_d_we    <= data_we;
        r_d_wdata <= data_wdata;
      end

      if (w_grant_d)      r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 3'd1;
      else if (w_grant_f) r_streak <= '0;

      mem_wea <= w_grant_d && w_d_we;
      if (w_grant_d) begin
        mem_addra <= w_d_addr;
        mem_dina  <= w_d_wdata;
        r_cur_we  <= w_d_we;
      end else if (w_grant_f) begin
        mem_addra <= w_f_addr;
      end

      // Memory read data is valid during WAIT_x, one cycle after ISSUE_x.
      fetch_done <= (r_state == WAIT_F);
      data_done  <= (r_state == WAIT_D);
      if ((r_state == WAIT_D) && !r_cur_we) data_rdata <= mem_douta;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural memory and IR.
module tb_mem_access_sequencer;

  logic        CLK;
  logic        reset;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_done;
  logic        data_req;
  logic        data_we;
  logic [9:0]  data_addr;
  logic [15:0] data_wdata;
  logic        data_done;
  logic [15:0] data_rdata;
  logic [9:0]  mem_addra;
  logic        mem_wea;
  logic [15:0] mem_dina;
  logic [15:0] mem_douta;
  logic        ir_write;
  logic        busy;

  logic [15:0] mem [0:1023];
  logic [15:0] ir;
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access_sequencer #(.ADDR_W(10), .DATA_W(16), .DATA_STREAK_MAX(2)) dut (
    .CLK(CLK), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
    .mem_addra(mem_addra), .mem_wea(mem_wea), .mem_dina(mem_dina),
    .mem_douta(mem_douta), .ir_write(ir_write), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 1K x 16 read-first memory with a preload port for the bench
  always @(posedge CLK) begin
    if (pl_en)        mem[pl_addr] <= pl_data;
    else if (mem_wea) mem[mem_addra] <= mem_dina;
    mem_douta <= mem[mem_addra];
  end

  always @(posedge CLK or negedge reset) begin
    if (!reset)        ir <= 16'h0;
    else if (ir_write) ir <= mem_douta;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int       iw_cnt;
    int       wea_cnt;
    int       done_cnt;
    int       nd;
    int       dp;
    int       fp;
    int       both;
    logic [6:0] order;
    logic     saw_wea;
    logic     saw_fd;

    reset = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    step(); step();
    check("rst_wea",   32'(mem_wea), 32'h0);
    check("rst_addra", 32'(mem_addra), 32'h0);
    check("rst_dina",  32'(mem_dina), 32'h0);
    check("rst_done",  32'({fetch_done, data_done}), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_irw",   32'(ir_write), 32'h0);
    check("rst_rdata", 32'(data_rdata), 32'h0);

    preload(10'h005, 16'hA3C1);
    preload(10'h010, 16'h1111);
    preload(10'h020, 16'h2222);
    preload(10'h001, 16'h0AAA);
    preload(10'h002, 16'h0BBB);
    preload(10'h100, 16'hBEEF);
    @(negedge CLK) reset = 1'b1;
    step();

    // single fetch
    fetch_req = 1'b1; fetch_addr = 10'h005;
    step();
    fetch_req = 1'b0;
    check("sf_issue_addr", 32'(mem_addra), 32'h005);
    check("sf_issue_irw",  32'(ir_write), 32'h0);
    check("sf_issue_busy", 32'(busy), 32'h1);
    iw_cnt = int'(ir_write);
    step();
    check("sf_wait_irw", 32'(ir_write), 32'h1);
    check("sf_wait_fd",  32'(fetch_done), 32'h0);
    iw_cnt += int'(ir_write);
    step();
    check("sf_fd",  32'(fetch_done), 32'h1);
    check("sf_ir",  32'(ir), 32'hA3C1);
    iw_cnt += int'(ir_write);
    step();
    iw_cnt += int'(ir_write);
    check("sf_fd_pulse", 32'(fetch_done), 32'h0);
    check("sf_irw_once", 32'(iw_cnt), 32'h1);
    check("sf_idle",     32'(busy), 32'h0);

    // simultaneous fetch and load: data first, fetch back-to-back
    fetch_req = 1'b1; fetch_addr = 10'h010;
    data_req = 1'b1; data_we = 1'b0; data_addr = 10'h020;
    step();
    fetch_req = 1'b0; data_req = 1'b0;
    check("sim_first_addr", 32'(mem_addra), 32'h020);
    check("sim_first_wea",  32'(mem_wea), 32'h0);
    step();
    check("sim_busy", 32'(busy), 32'h1);
    step();
    check("sim_dd",        32'(data_done), 32'h1);
    check("sim_rdata",     32'(data_rdata), 32'h2222);
    check("sim_f_addr",    32'(mem_addra), 32'h010);
    check("sim_fd_early",  32'(fetch_done), 32'h0);
    step();
    check("sim_irw",       32'(ir_write), 32'h1);
    check("sim_dd_pulse",  32'(data_done), 32'h0);
    step();
    check("sim_fd",        32'(fetch_done), 32'h1);
    check("sim_ir",        32'(ir), 32'h1111);
    step();

    // store then load at the top address
    data_req = 1'b1; data_we = 1'b1; data_addr = 10'h3FF; data_wdata = 16'h1234;
    step();
    data_req = 1'b0;
    check("st_wea_issue", 32'(mem_wea), 32'h1);
    wea_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wea_cnt  += int'(mem_wea);
      done_cnt += int'(data_done);
      if (i == 2) check("st_dd", 32'(data_done), 32'h1);
      step();
    end
    check("st_wea_once",  32'(wea_cnt), 32'h1);
    check("st_dd_once",   32'(done_cnt), 32'h1);
    check("st_mem",       32'(mem[10'h3FF]), 32'h1234);
    data_req = 1'b1; data_we = 1'b0; data_addr = 10'h3FF; data_wdata = 16'h0;
    step();
    data_req = 1'b0;
    check("ld_wea", 32'(mem_wea), 32'h0);
    step(); step();
    check("ld_dd",    32'(data_done), 32'h1);
    check("ld_rdata", 32'(data_rdata), 32'h1234);
    step();
    check("ld_hold",  32'(data_rdata), 32'h1234);

    // duplicate fetch while pending behind a load
    data_req = 1'b1; data_we = 1'b0; data_addr = 10'h020;
    step();
    data_req = 1'b0;
    fetch_req = 1'b1; fetch_addr = 10'h001;
    step();
    fetch_addr = 10'h002;
    step();
    fetch_req = 1'b0;
    check("dup_addr", 32'(mem_addra), 32'h001);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      done_cnt += int'(fetch_done);
    end
    check("dup_fd_once", 32'(done_cnt), 32'h1);
    check("dup_ir",      32'(ir), 32'h0AAA);
    check("dup_idle",    32'(busy), 32'h0);

    // starvation guard: data re-requested on each completion edge
    fetch_req = 1'b1; fetch_addr = 10'h005;
    data_req = 1'b1; data_we = 1'b1; data_addr = 10'h200; data_wdata = 16'h0;
    dp = 1; fp = 1; nd = 0; both = 0; order = '0;
    for (int c = 0; c < 60 && nd < 7; c++) begin
      @(negedge CLK);
      if (data_done && fetch_done) both++;
      if (data_done)  begin order = {order[5:0], 1'b1}; nd++; end
      if (fetch_done) begin order = {order[5:0], 1'b0}; nd++; end
      saw_wea = mem_wea;
      saw_fd  = fetch_done;
      @(posedge CLK); #1;
      fetch_req = 1'b0; data_req = 1'b0;
      if (saw_wea && dp < 5) begin
        data_req = 1'b1; data_we = 1'b1;
        data_addr = 10'h200 + 10'(dp); data_wdata = 16'(dp);
        dp++;
      end
      if (saw_fd && fp < 2) begin
        fetch_req = 1'b1; fetch_addr = 10'h002;
        fp++;
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    check("stv_count", 32'(nd), 32'd7);
    check("stv_order", 32'(order), 32'b1101101);
    check("stv_no_both", 32'(both), 32'h0);
    check("stv_ir", 32'(ir), 32'h0BBB);
    check("stv_mem4", 32'(mem[10'h204]), 32'h0004);
    step(); step(); step();
    check("stv_idle", 32'(busy), 32'h0);

    // reset in the middle of a store
    data_req = 1'b1; data_we = 1'b1; data_addr = 10'h100; data_wdata = 16'h5555;
    step();
    data_req = 1'b0;
    check("rs_wea_before", 32'(mem_wea), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rs_wea_async", 32'(mem_wea), 32'h0);
    check("rs_addra",     32'(mem_addra), 32'h0);
    check("rs_busy",      32'(busy), 32'h0);
    check("rs_rdata",     32'(data_rdata), 32'h0);
    fetch_req = 1'b1; fetch_addr = 10'h005;
    step(); step(); step();
    fetch_req = 1'b0;
    check("rs_mem_kept", 32'(mem[10'h100]), 32'hBEEF);
    @(negedge CLK) reset = 1'b1;
    step(); step();
    check("rs_req_ignored", 32'(busy), 32'h0);
    check("rs_no_done",     32'({fetch_done, data_done}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
